// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg: constants and types shared by the debug dump path.
//   - NB_BYTE / BYTES_PER_WORD: stream byte width and bytes per default word.
//   - CKSUM_SEED: initial value of the running XOR. The debug-unit parser
//     starts its own XOR from this same value.
//   - dump_state_e: dump FSM states. ST_CKSUM exists only when
//     MEM_DUMP_CHECKSUM_EN is defined.
package mips_debug_pkg;

  localparam int unsigned NB_BYTE         = 8;
  localparam int unsigned NB_DATA_DEFAULT = 32;
  localparam int unsigned BYTES_PER_WORD  = NB_DATA_DEFAULT / NB_BYTE;

  localparam logic [NB_BYTE-1:0] CKSUM_SEED = '0;

  function automatic int unsigned bytes_per_word(input int unsigned nb_data,
                                                 input int unsigned nb_byte);
    return nb_data / nb_byte;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
`ifdef MEM_DUMP_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/mem_dump_reader_word_serializer.sv
// word_serializer: holds one word and hands it out byte by byte, MSB first.
// It is also meant to be reused by the register-file and PC dump paths.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_load, i_data   : capture a new word and restart the byte counter
//   i_shift          : advance to the next byte (ignored while i_load is high)
//   o_next_byte      : byte that becomes the top byte after the next shift
//   o_last           : the current top byte is the last byte of the word
module word_serializer
  import mips_debug_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = mips_debug_pkg::NB_BYTE
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_shift,
  output logic [NB_BYTE-1:0] o_next_byte,
  output logic               o_last
);

  localparam int unsigned BPW    = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int unsigned NB_IDX = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(BPW - 1);

  logic [NB_DATA-1:0] shift_q, shift_d, shifted;
  logic [NB_IDX-1:0]  byte_idx_q, byte_idx_d;

  always_comb begin
    shifted    = shift_q << NB_BYTE;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    if (i_load) begin
      shift_d    = i_data;
      byte_idx_d = '0;
    end else if (i_shift) begin
      shift_d    = shifted;
      byte_idx_d = byte_idx_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // The owner keeps its own registered copy of the byte it presents, so it
  // needs to see the byte that comes next rather than the current one.
  assign o_next_byte = shifted[NB_DATA-1 -: NB_BYTE];
  assign o_last      = (byte_idx_q == LAST_IDX);

endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: on request, reads data-memory words 0..N_WORDS-1 through
// the debug read port and streams each word MSB byte first to the UART TX.
// Optional: MEM_DUMP_CHECKSUM_EN appends one XOR-of-all-bytes trailer byte.
//   i_clock, i_reset            : clock, asynchronous active-high reset
//   i_start                     : dump request, honoured only when idle
//   o_busy, o_done              : not-idle flag, one-cycle completion pulse
//   o_mem_address/_read_enable  : word address and one-cycle read strobe
//   i_mem_read_data             : registered read data (one cycle after strobe)
//   o_tx_data/_valid, i_tx_ready: byte stream, transfer on valid & ready
// Every output comes directly from a flop.
module mem_dump_reader
  import mips_debug_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 5,
  parameter int unsigned N_WORDS = 32,
  parameter int unsigned NB_BYTE = mips_debug_pkg::NB_BYTE
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_ADDR-1:0] o_mem_address,
  output logic               o_mem_read_enable,
  input  logic [NB_DATA-1:0] i_mem_read_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);

  dump_state_e        state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic               ren_q, ren_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] cksum_q, cksum_d;
`endif

  logic               ser_load, ser_shift, ser_last;
  logic [NB_BYTE-1:0] ser_next_byte;
  logic               handshake;

  word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_word_serializer (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (ser_load),
    .i_data      (i_mem_read_data),
    .i_shift     (ser_shift),
    .o_next_byte (ser_next_byte),
    .o_last      (ser_last)
  );

  assign handshake = valid_q & i_tx_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ren_d     = 1'b0;
    valid_d   = valid_q;
    tx_data_d = tx_data_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
    cksum_d   = cksum_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_REQ;
          addr_d  = '0;
          ren_d   = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
          cksum_d = CKSUM_SEED;
`endif
        end
      end

      ST_REQ: state_d = ST_WAIT;

      // Read data is valid now: the top byte goes straight into the output
      // flop while the whole word is loaded into the serializer, so valid
      // rises two edges after the start is sampled.
      ST_WAIT: begin
        ser_load  = 1'b1;
        tx_data_d = i_mem_read_data[NB_DATA-1 -: NB_BYTE];
        valid_d   = 1'b1;
        state_d   = ST_SEND;
      end

      ST_SEND: begin
        if (handshake) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          cksum_d = cksum_q ^ tx_data_q;
`endif
          if (!ser_last) begin
            ser_shift = 1'b1;
            tx_data_d = ser_next_byte;
          end else if (addr_q == LAST_ADDR) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            // Valid stays high: the trailer byte follows without a gap.
            tx_data_d = cksum_q ^ tx_data_q;
            state_d   = ST_CKSUM;
`else
            valid_d   = 1'b0;
            state_d   = ST_DONE;
`endif
          end else begin
            valid_d = 1'b0;
            addr_d  = addr_q + 1'b1;
            ren_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end

`ifdef MEM_DUMP_CHECKSUM_EN
      ST_CKSUM: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      ren_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_data_q <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      cksum_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ren_q     <= ren_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_data_q <= tx_data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      cksum_q   <= cksum_d;
`endif
    end
  end

  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_mem_address     = addr_q;
  assign o_mem_read_enable = ren_q;
  assign o_tx_data         = tx_data_q;
  assign o_tx_valid        = valid_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
`timescale 1ns/1ps
module tb_mem_dump_reader;

  localparam int unsigned NW = 32;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int unsigned CK = 1;
`else
  localparam int unsigned CK = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        tx_ready = 1'b0;
  logic        sel = 1'b0;

  // DUT 0: full 32-word dump
  logic        start0 = 1'b0, busy0, done0, ren0, txv0;
  logic [4:0]  addr0;
  logic [31:0] rdata0 = '0;
  logic [7:0]  txd0;
  logic [31:0] mem0 [NW];

  // DUT 1: single-word dump
  logic        start1 = 1'b0, busy1, done1, ren1, txv1;
  logic [4:0]  addr1;
  logic [31:0] rdata1 = '0;
  logic [7:0]  txd1;
  logic [31:0] mem1_word = '0;

  mem_dump_reader #(.NB_DATA(32), .NB_ADDR(5), .N_WORDS(NW), .NB_BYTE(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start0), .o_busy(busy0), .o_done(done0),
    .o_mem_address(addr0), .o_mem_read_enable(ren0), .i_mem_read_data(rdata0),
    .o_tx_data(txd0), .o_tx_valid(txv0), .i_tx_ready(tx_ready));

  mem_dump_reader #(.NB_DATA(32), .NB_ADDR(5), .N_WORDS(1), .NB_BYTE(8)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_mem_address(addr1), .o_mem_read_enable(ren1), .i_mem_read_data(rdata1),
    .o_tx_data(txd1), .o_tx_valid(txv1), .i_tx_ready(tx_ready));

  // Registered-read memories
  always @(posedge clk) if (ren0) rdata0 <= mem0[addr0];
  always @(posedge clk) if (ren1) rdata1 <= mem1_word;

  logic       mv, mdone, mbusy, mren;
  logic [7:0] md;
  logic [4:0] maddr;
  always_comb begin
    if (sel) begin
      mv = txv1; mdone = done1; mbusy = busy1; mren = ren1; md = txd1; maddr = addr1;
    end else begin
      mv = txv0; mdone = done0; mbusy = busy0; mren = ren0; md = txd0; maddr = addr0;
    end
  end

  int unsigned total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the expected byte stream is each word, MSB byte first,
  // in address order, optionally followed by the XOR of all bytes.
  logic [7:0] exp_q [$];
  logic [7:0] first_rx, last_rx;

  task automatic build_expected(input int unsigned nwords);
    logic [7:0] x;
    logic [31:0] w;
    x = '0;
    exp_q.delete();
    for (int unsigned k = 0; k < nwords; k++) begin
      w = sel ? mem1_word : mem0[k];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[31-8*b -: 8]);
        x ^= w[31-8*b -: 8];
      end
    end
    if (CK != 0) exp_q.push_back(x);
  endtask

  // With ready always high: first byte 3 edges after the start edge, words of
  // 4 back-to-back bytes spaced 6 edges apart, trailer right after the last.
  function automatic int unsigned exp_edge(input int unsigned s, input int unsigned i,
                                           input int unsigned nwords);
    if (i < 4*nwords) return s + 3 + 6*(i/4) + (i%4);
    return s + 6*nwords + 1;
  endfunction

  // mode 0: ready high, 1: random ready, 2: 5-cycle stall on byte index 2
  task automatic run_dump(input int mode, input int busy_start_at, input int abort_at);
    int unsigned nw, s, nx, ren_n, hold, budget, last_edge;
    logic prev_v, prev_x, prev_ren, got_done, pulsed, v, x;
    logic [7:0] prev_d;
    logic [4:0] prev_a;
    nw = sel ? 1 : NW;
    nx = 0; ren_n = 0; hold = 0; budget = 3000; last_edge = 0;
    prev_v = 0; prev_x = 0; prev_ren = 0; got_done = 0; pulsed = 0;
    prev_d = '0; prev_a = '0;
    build_expected(nw);
    @(posedge clk); #1;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    start0 = 1'b0; start1 = 1'b0;
    while (!got_done && budget > 0) begin
      budget--;
      if (abort_at >= 0 && nx == 32'(abort_at) && mv) begin
        rst = 1'b1;
        #1;
        check("rst_busy",  32'(busy0), 0);
        check("rst_done",  32'(done0), 0);
        check("rst_addr",  32'(addr0), 0);
        check("rst_ren",   32'(ren0),  0);
        check("rst_txd",   32'(txd0),  0);
        check("rst_valid", 32'(txv0),  0);
        return;
      end
      if (busy_start_at >= 0 && nx == 32'(busy_start_at) && !pulsed) begin
        start0 = 1'b1; pulsed = 1'b1;
      end else begin
        start0 = 1'b0;
      end
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ($urandom_range(0, 9) < 7);
        default: begin
          if (nx == 2 && mv && hold < 5) begin tx_ready = 1'b0; hold++; end
          else tx_ready = 1'b1;
        end
      endcase
      @(negedge clk);
      v = mv;
      x = mv & tx_ready;
      if (!mdone) check("busy_during", 32'(mbusy), 1);
      if (prev_v && !prev_x) begin
        check("valid_hold", 32'(v), 1);
        check("data_hold", 32'(md), 32'(prev_d));
        check("addr_hold", 32'(maddr), 32'(prev_a));
      end
      if (mren) begin
        check("read_addr", 32'(maddr), ren_n);
        check("read_one_cycle", 32'(prev_ren), 0);
        ren_n++;
      end
      if (v) begin
        if (nx < exp_q.size()) check("byte", 32'(md), 32'(exp_q[nx]));
        else check("extra_byte", nx, exp_q.size());
        if (x) begin
          if (mode == 0) check("xfer_edge", cyc + 1, exp_edge(s, nx, nw));
          if (nx == 0) first_rx = md;
          last_rx = md;
          last_edge = cyc + 1;
          nx++;
        end
      end
      if (mdone) begin
        got_done = 1'b1;
        check("done_edge", cyc, last_edge);
        check("busy_at_done", 32'(mbusy), 1);
        check("n_bytes", nx, exp_q.size());
        check("n_reads", ren_n, nw);
        if (mode == 0) check("done_latency", cyc - s, 6*nw + CK);
      end
      prev_v = v; prev_x = x; prev_d = md; prev_a = maddr; prev_ren = mren;
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    check("done_seen", 32'(got_done), 1);
    @(negedge clk);
    check("done_one_cycle", 32'(mdone), 0);
    check("idle_after", 32'(mbusy), 0);
    @(posedge clk); #1;
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < int'(NW); k++) mem0[k] = $urandom;
    mem1_word = $urandom;
  endtask

  initial begin
    randomize_mem();

    // Reset held, start pulsed during reset
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    start0 = 1'b1; start1 = 1'b1; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",  32'(busy0), 0);
    check("reset_done",  32'(done0), 0);
    check("reset_addr",  32'(addr0), 0);
    check("reset_ren",   32'(ren0),  0);
    check("reset_txd",   32'(txd0),  0);
    check("reset_valid", 32'(txv0),  0);
    check("reset_busy1", 32'(busy1), 0);
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_busy",  32'(busy0), 0);
      check("post_reset_valid", 32'(txv0),  0);
      check("post_reset_ren",   32'(ren0),  0);
    end
    @(posedge clk); #1;

    // Single word
    sel = 1'b1;
    mem1_word = 32'hDEADBEEF;
    run_dump(0, -1, -1);
    check("single_first", 32'(first_rx), 32'hDE);
    sel = 1'b0;

    // Full dump with a known pattern
    for (int k = 0; k < int'(NW); k++) mem0[k] = 32'h11223300 + k;
    run_dump(0, -1, -1);
    check("full_first", 32'(first_rx), 32'h11);
`ifndef MEM_DUMP_CHECKSUM_EN
    check("full_last", 32'(last_rx), 32'h1F);
`endif

    // Backpressure on byte 0xBE
    randomize_mem();
    mem0[0] = 32'hDEADBEEF;
    run_dump(2, -1, -1);

    // Start while busy at word 10 is ignored
    randomize_mem();
    run_dump(0, 40, -1);

    // Reset at word 3 byte 2, then a fresh dump restarts at address 0
    randomize_mem();
    run_dump(1, -1, 14);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_dump(0, -1, -1);
    check("restart_first", 32'(first_rx), 32'(mem0[0][31:24]));

    // Random contents, random ready
    for (int r = 0; r < 3; r++) begin
      randomize_mem();
      run_dump(1, -1, -1);
    end
    sel = 1'b1;
    randomize_mem();
    run_dump(1, -1, -1);
    sel = 1'b0;

`ifdef MEM_DUMP_CHECKSUM_EN
    for (int k = 0; k < int'(NW); k++) mem0[k] = '0;
    mem0[0] = 32'h000000FF;
    run_dump(0, -1, -1);
    check("cksum_ff", 32'(last_rx), 32'hFF);
    mem0[0] = 32'hA5A5A5A5;
    run_dump(1, -1, -1);
    check("cksum_a5", 32'(last_rx), 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
